// File: rtl/special_keys_ctrl.sv
// special_keys_ctrl
// Merges PS/2 function keys (active-low) with membrane function keys
// (active-high) into one vector of special keys, then synchronises and
// debounces every channel.
// The two top channels (multiface/NMI and drive/mmc) also feed long-press
// detectors whose outputs drive the machine's button logic.
//
// Ports:
//   clk_peripheral       - system peripheral clock
//   reset                - synchronous, active-high reset
//   ps2_func_keys_n      - PS/2 function keys F1.., active-low
//   membrane_fnkeys      - membrane function keys, active-high
//   ps2_mf_n             - PS/2 multiface key, active-low
//   ps2_mmc_n            - PS/2 drive/mmc key, active-low
//   spkey_function       - debounced key levels
//   spkey_function_pulse - one-cycle pulse on each debounced rising edge
//   spkey_buttons        - [0] multiface/NMI long press, [1] drive/mmc long press
module special_keys_ctrl #(
  parameter int unsigned NUM_PS2_FKEYS   = 8,
  parameter int unsigned NUM_FKEYS       = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1024
) (
  input  logic                     clk_peripheral,
  input  logic                     reset,
  input  logic [NUM_PS2_FKEYS-1:0] ps2_func_keys_n,
  input  logic [NUM_FKEYS-1:0]     membrane_fnkeys,
  input  logic                     ps2_mf_n,
  input  logic                     ps2_mmc_n,
  output logic [NUM_FKEYS-1:0]     spkey_function,
  output logic [NUM_FKEYS-1:0]     spkey_function_pulse,
  output logic [1:0]               spkey_buttons
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam int unsigned MF_CH  = NUM_FKEYS - 2;
  localparam int unsigned MMC_CH = NUM_FKEYS - 1;

  logic [NUM_FKEYS-1:0] raw;
  logic [NUM_FKEYS-1:0] s1;
  logic [NUM_FKEYS-1:0] s2;
  logic [NUM_FKEYS-1:0] stable;
  logic [NUM_FKEYS-1:0] pulse;
  logic [DB_W-1:0]      db_cnt   [NUM_FKEYS];
  logic [HOLD_W-1:0]    hold_cnt [2];

  // Both sources of a channel are ORed before synchronisation, so overlapping
  // presses from PS/2 and membrane form a single press.
  always_comb begin
    raw = membrane_fnkeys;
    for (int unsigned i = 0; i < NUM_PS2_FKEYS; i++) begin
      raw[i] = membrane_fnkeys[i] | ~ps2_func_keys_n[i];
    end
    raw[MF_CH]  = membrane_fnkeys[MF_CH]  | ~ps2_mf_n;
    raw[MMC_CH] = membrane_fnkeys[MMC_CH] | ~ps2_mmc_n;
  end

  // Sync, debounce and press pulse. The counter is cleared on any cycle where
  // s2 agrees with the accepted level, so a glitch restarts the count.
  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      pulse  <= '0;
      for (int unsigned i = 0; i < NUM_FKEYS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int unsigned i = 0; i < NUM_FKEYS; i++) begin
        pulse[i] <= 1'b0;
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          pulse[i]  <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Long-press counters saturate at HOLD_CYCLES so indefinite holds never wrap.
  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      for (int unsigned k = 0; k < 2; k++) begin
        hold_cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (!stable[MF_CH + k]) begin
          hold_cnt[k] <= '0;
        end else if (hold_cnt[k] != HOLD_MAX) begin
          hold_cnt[k] <= hold_cnt[k] + HOLD_W'(1);
        end
      end
    end
  end

  always_comb begin
    spkey_buttons = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      spkey_buttons[k] = (hold_cnt[k] == HOLD_MAX);
    end
  end

  assign spkey_function       = stable;
  assign spkey_function_pulse = pulse;

endmodule

// File: tb/tb_special_keys_ctrl.sv
// Directed bench for special_keys_ctrl with DEBOUNCE_CYCLES = 4 and
// HOLD_CYCLES = 16. Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, so "step n" is the n-th edge after a change.
module tb_special_keys_ctrl;

  localparam int unsigned NP = 8;
  localparam int unsigned NF = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] ps2_func_keys_n;
  logic [NF-1:0] membrane_fnkeys;
  logic          ps2_mf_n;
  logic          ps2_mmc_n;
  logic [NF-1:0] spkey_function;
  logic [NF-1:0] spkey_function_pulse;
  logic [1:0]    spkey_buttons;

  int n_checks = 0;
  int n_fail   = 0;

  special_keys_ctrl #(
    .NUM_PS2_FKEYS  (NP),
    .NUM_FKEYS      (NF),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16)
  ) dut (
    .clk_peripheral      (clk),
    .reset               (reset),
    .ps2_func_keys_n     (ps2_func_keys_n),
    .membrane_fnkeys     (membrane_fnkeys),
    .ps2_mf_n            (ps2_mf_n),
    .ps2_mmc_n           (ps2_mmc_n),
    .spkey_function      (spkey_function),
    .spkey_function_pulse(spkey_function_pulse),
    .spkey_buttons       (spkey_buttons)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_level"},  32'(spkey_function),       32'h0);
    check({tag, "_pulse"},  32'(spkey_function_pulse), 32'h0);
    check({tag, "_button"}, 32'(spkey_buttons),        32'h0);
  endtask

  initial begin
    int pulses;
    reset           = 1'b1;
    ps2_func_keys_n = '1;
    membrane_fnkeys = '0;
    ps2_mf_n        = 1'b1;
    ps2_mmc_n       = 1'b1;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("post_reset");

    // 1: PS/2 F1 press and release
    ps2_func_keys_n[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      check("t1_press_level", 32'(spkey_function),       (n >= 6) ? 32'h1 : 32'h0);
      check("t1_press_pulse", 32'(spkey_function_pulse), (n == 6) ? 32'h1 : 32'h0);
    end
    ps2_func_keys_n[0] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      check("t1_rel_level", 32'(spkey_function),       (n < 6) ? 32'h1 : 32'h0);
      check("t1_rel_pulse", 32'(spkey_function_pulse), 32'h0);
    end

    // 2: short glitchy presses never accepted
    for (int n = 1; n <= 16; n++) begin
      membrane_fnkeys[3] = (n <= 3) || (n >= 5 && n <= 7);
      step();
      check("t2_level", 32'(spkey_function),       32'h0);
      check("t2_pulse", 32'(spkey_function_pulse), 32'h0);
    end
    membrane_fnkeys[3] = 1'b0;

    // 3: multiface long press, saturation, release
    ps2_mf_n = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      check("t3_level",  32'(spkey_function),       (n >= 6)  ? 32'h100 : 32'h0);
      check("t3_pulse",  32'(spkey_function_pulse), (n == 6)  ? 32'h100 : 32'h0);
      check("t3_button", 32'(spkey_buttons),        (n >= 22) ? 32'h1   : 32'h0);
    end
    ps2_mf_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      check("t3_rel_level",  32'(spkey_function), (n < 6) ? 32'h100 : 32'h0);
      check("t3_rel_button", 32'(spkey_buttons),  (n < 7) ? 32'h1   : 32'h0);
    end

    // 4: short drive/mmc press gives pulse only
    pulses = 0;
    membrane_fnkeys[9] = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      if (n == 11) membrane_fnkeys[9] = 1'b0;
      step();
      if (spkey_function_pulse[9]) pulses++;
      check("t4_level",  32'(spkey_function), (n >= 6 && n < 16) ? 32'h200 : 32'h0);
      check("t4_button", 32'(spkey_buttons),  32'h0);
    end
    check("t4_pulses", 32'(pulses), 32'd1);

    // 5: overlapping membrane and PS/2 multiface presses merge
    pulses = 0;
    membrane_fnkeys[8] = 1'b1;
    for (int n = 1; n <= 62; n++) begin
      step();
      if (spkey_function_pulse[8]) pulses++;
      check("t5_level",  32'(spkey_function), (n >= 6 && n < 56)  ? 32'h100 : 32'h0);
      check("t5_button", 32'(spkey_buttons),  (n >= 22 && n < 57) ? 32'h1   : 32'h0);
      if (n == 20) ps2_mf_n = 1'b0;
      if (n == 30) membrane_fnkeys[8] = 1'b0;
      if (n == 50) ps2_mf_n = 1'b1;
    end
    check("t5_pulses", 32'(pulses), 32'd1);

    // 6: reset in the middle of a long press on drive/mmc
    ps2_mmc_n = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      step();
    end
    check("t6_pre_level",  32'(spkey_function), 32'h200);
    check("t6_pre_button", 32'(spkey_buttons),  32'h2);
    reset = 1'b1;
    step();
    check_idle("t6_reset");
    reset = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      step();
      check("t6_level",  32'(spkey_function),       (n >= 6)  ? 32'h200 : 32'h0);
      check("t6_pulse",  32'(spkey_function_pulse), (n == 6)  ? 32'h200 : 32'h0);
      check("t6_button", 32'(spkey_buttons),        (n >= 22) ? 32'h2   : 32'h0);
    end
    ps2_mmc_n = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
    end
    check_idle("t6_released");

    // 7: all channels change together
    ps2_func_keys_n = '0;
    ps2_mf_n        = 1'b0;
    ps2_mmc_n       = 1'b0;
    for (int n = 1; n <= 7; n++) begin
      step();
      check("t7_level", 32'(spkey_function),       (n >= 6) ? 32'h3FF : 32'h0);
      check("t7_pulse", 32'(spkey_function_pulse), (n == 6) ? 32'h3FF : 32'h0);
    end
    ps2_func_keys_n = '1;
    ps2_mf_n        = 1'b1;
    ps2_mmc_n       = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
    end
    check_idle("t7_released");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
